// File: rtl/fft_chan_sched.sv
// rtl/fft_chan_sched.sv - round-robin scheduler sharing one FFT engine among NCH channels
module fft_chan_sched #(
  parameter int NCH   = 4,
  parameter int N     = 16,
  parameter int SIZE  = 4,
  parameter int TMO   = 1023,
  parameter int TMO_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  src_valid,
  input  logic [NCH-1:0]  chan_ready,
  input  logic            fft_out_valid,
  input  logic            fft_done,
  output logic [NCH-1:0]  gnt,
  output logic [2:0]      ld_sel,
  output logic            ld_en,
  output logic [SIZE-1:0] ld_addr,
  output logic            fft_start,
  output logic            fft_en_out_data,
  output logic [NCH-1:0]  chan_out_valid,
  output logic [NCH-1:0]  ack,
  output logic            err_tmo,
  output logic            busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       r_rr_ptr;
  logic [TMO_W-1:0] r_wd_cnt;
  logic [NCH-1:0]   r_gnt;
  logic [2:0]       r_ld_sel;
  logic [SIZE-1:0]  r_ld_addr;
  logic             r_err_tmo;

  logic             w_found;
  logic [2:0]       w_win;
  logic             w_ld_en;

  // First requester at or after rr_ptr, scanning upward with wrap.
  always_comb begin
    int j;
    w_found = 1'b0;
    w_win   = '0;
    j       = 0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(r_rr_ptr) + i;
      if (j >= NCH) j = j - NCH;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_win   = 3'(j);
      end
    end
  end

  // gnt is one-hot, so masking with it selects the granted channel's bit.
  assign w_ld_en = (r_state == S_LOAD) && |(src_valid & r_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_wd_cnt  <= '0;
      r_gnt     <= '0;
      r_ld_sel  <= '0;
      r_ld_addr <= '0;
      r_err_tmo <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt     <= {{(NCH-1){1'b0}}, 1'b1} << w_win;
            r_ld_sel  <= w_win;
            r_ld_addr <= '0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_ld_en) begin
            r_ld_addr <= r_ld_addr + 1'b1;
            if (r_ld_addr == SIZE'(N - 1)) r_state <= S_START;
          end
        end
        S_START: begin
          r_wd_cnt <= '0;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          if (fft_done) begin
            r_state <= S_RELEASE;
          end else if (r_wd_cnt == TMO_W'(TMO)) begin
            r_err_tmo <= 1'b1;
            r_state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_gnt    <= '0;
          r_rr_ptr <= (r_ld_sel == 3'(NCH - 1)) ? 3'd0 : r_ld_sel + 3'd1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt             = r_gnt;
  assign ld_sel          = r_ld_sel;
  assign ld_en           = w_ld_en;
  assign ld_addr         = r_ld_addr;
  assign fft_start       = (r_state == S_START);
  assign fft_en_out_data = (r_state == S_RUN) && |(chan_ready & r_gnt);
  assign chan_out_valid  = (r_state == S_RUN) ? (r_gnt & {NCH{fft_out_valid}}) : '0;
  assign ack             = (r_state == S_RELEASE) ? r_gnt : '0;
  assign err_tmo         = r_err_tmo;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_fft_chan_sched.sv
// tb/tb_fft_chan_sched.sv - directed self-checking bench for fft_chan_sched
module tb_fft_chan_sched;
  localparam int NCH = 4;
  localparam int N = 16;
  localparam int SIZE = 4;
  localparam int TMO = 20;
  localparam int TMO_W = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH-1:0] req, src_valid, chan_ready;
  logic fft_out_valid, fft_done;
  logic [NCH-1:0] gnt, chan_out_valid, ack;
  logic [2:0] ld_sel;
  logic ld_en, fft_start, fft_en_out_data, err_tmo, busy;
  logic [SIZE-1:0] ld_addr;

  int n_checks = 0;
  int n_fail = 0;

  fft_chan_sched #(.NCH(NCH), .N(N), .SIZE(SIZE), .TMO(TMO), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_valid(src_valid), .chan_ready(chan_ready),
    .fft_out_valid(fft_out_valid), .fft_done(fft_done), .gnt(gnt), .ld_sel(ld_sel),
    .ld_en(ld_en), .ld_addr(ld_addr), .fft_start(fft_start), .fft_en_out_data(fft_en_out_data),
    .chan_out_valid(chan_out_valid), .ack(ack), .err_tmo(err_tmo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the current job from LOAD to its ack; done_at<=0 means no fft_done.
  task automatic drive_job(input int done_at, output logic [NCH-1:0] ack_v, output int lat);
    int guard;
    guard = 0;
    lat = 0;
    while (fft_start !== 1'b1 && guard < 100) begin tick(); guard++; end
    if (done_at > 0) begin
      repeat (done_at) begin tick(); lat++; end
      fft_done = 1'b1;
      tick();
      lat++;
      fft_done = 1'b0;
    end
    guard = 0;
    while (ack === '0 && guard < 100) begin tick(); lat++; guard++; end
    ack_v = ack;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; src_valid = '0; chan_ready = '0;
    fft_out_valid = 1'b0; fft_done = 1'b0;
    tick(); tick();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b exp 0000", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (ld_addr !== 4'd0 || ld_sel !== 3'd0) begin n_fail++; $display("FAIL reset_addr_sel: got %0d/%0d exp 0/0", ld_addr, ld_sel); end
    n_checks++; if ({ack, err_tmo, fft_start, ld_en} !== 7'd0) begin n_fail++; $display("FAIL reset_misc: got %b exp 0", {ack, err_tmo, fft_start, ld_en}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_request();
    logic [NCH-1:0] a;
    int lat, exp_ch;
    req = 4'b1111; src_valid = 4'b1111;
    tick();
    for (int j = 0; j < 5; j++) begin
      exp_ch = j % NCH;
      n_checks++; if (gnt !== (4'b0001 << exp_ch) || ld_sel !== 3'(exp_ch)) begin n_fail++; $display("FAIL rr_gnt_%0d: got %b/%0d exp ch %0d", j, gnt, ld_sel, exp_ch); end
      drive_job(5, a, lat);
      n_checks++; if (a !== (4'b0001 << exp_ch)) begin n_fail++; $display("FAIL rr_ack_%0d: got %b exp ch %0d", j, a, exp_ch); end
      if (j == 4) req = '0;
      tick();
      n_checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_gap_%0d: got busy %b gnt %b exp 0", j, busy, gnt); end
      if (j < 4) tick();
    end
  endtask

  task automatic test_single_requester();
    logic [NCH-1:0] a;
    int lat, bad;
    req = 4'b0100; src_valid = 4'b1111;
    tick();
    n_checks++; if (gnt !== 4'b0100 || ld_sel !== 3'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b/%0d/%b exp 0100/2/1", gnt, ld_sel, busy); end
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (ld_addr !== 4'(k) || ld_en !== 1'b1 || fft_start !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL single_addr_seq: got %0d bad cycles exp 0", bad); end
    n_checks++; if (fft_start !== 1'b1 || ld_addr !== 4'd0) begin n_fail++; $display("FAIL single_start: got %b addr %0d exp 1 addr 0", fft_start, ld_addr); end
    req = '0;
    drive_job(10, a, lat);
    n_checks++; if (a !== 4'b0100 || lat !== 11) begin n_fail++; $display("FAIL single_ack: got %b lat %0d exp 0100 lat 11", a, lat); end
    tick();
    n_checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got ack %b busy %b exp 0000/0", ack, busy); end
  endtask

  task automatic test_load_stall();
    logic [NCH-1:0] a;
    int lat, pulses, bad, last_cyc, start_cyc, cyc;
    req = 4'b0010; src_valid = 4'b0000;
    tick();
    req = '0;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL stall_gnt: got %b exp 0010", gnt); end
    pulses = 0; bad = 0; last_cyc = -1; start_cyc = -1; cyc = 0;
    while (start_cyc < 0 && cyc < 60) begin
      src_valid = (cyc % 2 == 1) ? 4'b1111 : 4'b0000;
      #1;
      if (fft_start === 1'b1) start_cyc = cyc;
      else if (src_valid[1]) begin
        if (ld_en !== 1'b1 || ld_addr !== 4'(pulses)) bad++;
        pulses++; last_cyc = cyc;
      end else if (ld_en !== 1'b0) bad++;
      if (start_cyc < 0) begin tick(); cyc++; end
    end
    src_valid = 4'b1111;
    n_checks++; if (pulses !== 16) begin n_fail++; $display("FAIL stall_pulses: got %0d exp 16", pulses); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stall_addr: got %0d bad cycles exp 0", bad); end
    n_checks++; if (start_cyc !== last_cyc + 1) begin n_fail++; $display("FAIL stall_start: got cycle %0d exp %0d", start_cyc, last_cyc + 1); end
    drive_job(3, a, lat);
    n_checks++; if (a !== 4'b0010) begin n_fail++; $display("FAIL stall_ack: got %b exp 0010", a); end
    tick();
  endtask

  task automatic test_drain_routing();
    int guard;
    req = 4'b0010; src_valid = 4'b1111;
    tick();
    req = '0;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL drain_gnt: got %b exp 0010", gnt); end
    fft_out_valid = 1'b1; chan_ready = 4'b1111; #1;
    n_checks++; if (chan_out_valid !== 4'b0000 || fft_en_out_data !== 1'b0) begin n_fail++; $display("FAIL drain_gated_load: got %b/%b exp 0000/0", chan_out_valid, fft_en_out_data); end
    guard = 0;
    while (fft_start !== 1'b1 && guard < 100) begin tick(); guard++; end
    tick();
    chan_ready = 4'b1101; #1;
    n_checks++; if (fft_en_out_data !== 1'b0) begin n_fail++; $display("FAIL drain_not_ready: got %b exp 0", fft_en_out_data); end
    n_checks++; if (chan_out_valid !== 4'b0010) begin n_fail++; $display("FAIL drain_route: got %b exp 0010", chan_out_valid); end
    chan_ready = 4'b0010; #1;
    n_checks++; if (fft_en_out_data !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %b exp 1", fft_en_out_data); end
    fft_out_valid = 1'b0; #1;
    n_checks++; if (chan_out_valid !== 4'b0000) begin n_fail++; $display("FAIL drain_novalid: got %b exp 0000", chan_out_valid); end
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL drain_ack: got %b exp 0010", ack); end
    chan_ready = '0;
    tick();
  endtask

  task automatic test_timeout();
    logic [NCH-1:0] a;
    int lat, guard;
    req = 4'b0101; src_valid = 4'b1111;
    tick();
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL tmo_gnt_a: got %b exp 0100", gnt); end
    drive_job(TMO + 1, a, lat);
    n_checks++; if (a !== 4'b0100 || lat !== TMO + 2 || err_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_done_wins: got %b lat %0d err %b exp 0100 lat %0d err 0", a, lat, err_tmo, TMO + 2); end
    tick(); tick();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL tmo_gnt_b: got %b exp 0001", gnt); end
    drive_job(0, a, lat);
    n_checks++; if (a !== 4'b0001 || lat !== TMO + 2) begin n_fail++; $display("FAIL tmo_ack: got %b lat %0d exp 0001 lat %0d", a, lat, TMO + 2); end
    n_checks++; if (err_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b exp 1", err_tmo); end
    tick(); tick();
    req = '0;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL tmo_next_gnt: got %b exp 0100", gnt); end
    guard = 0;
    while (fft_start !== 1'b1 && guard < 100) begin tick(); guard++; end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [NCH-1:0] a;
    int lat;
    fft_out_valid = 1'b1; chan_ready = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({gnt, busy, ld_addr, ld_sel, ack, err_tmo, fft_start, ld_en, chan_out_valid, fft_en_out_data} !== '0) begin
      n_fail++; $display("FAIL async_reset: got gnt %b busy %b err %b cov %b en %b exp all 0", gnt, busy, err_tmo, chan_out_valid, fft_en_out_data);
    end
    fft_out_valid = 1'b0; chan_ready = '0;
    tick();
    rst_n = 1'b1;
    req = 4'b1001;
    tick();
    req = '0;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rr_restart: got %b exp 0001", gnt); end
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    n_checks++; if (busy !== 1'b1 || ld_addr !== 4'd1 || ack !== 4'b0000 || fft_start !== 1'b0) begin n_fail++; $display("FAIL stray_done: got busy %b addr %0d ack %b exp 1/1/0000", busy, ld_addr, ack); end
    drive_job(3, a, lat);
    n_checks++; if (a !== 4'b0001) begin n_fail++; $display("FAIL stray_ack: got %b exp 0001", a); end
    req = 4'b1000;
    tick(); tick();
    req = '0;
    n_checks++; if (gnt !== 4'b1000 || ld_sel !== 3'd3) begin n_fail++; $display("FAIL ch3_gnt: got %b/%0d exp 1000/3", gnt, ld_sel); end
    drive_job(2, a, lat);
    n_checks++; if (a !== 4'b1000) begin n_fail++; $display("FAIL ch3_ack: got %b exp 1000", a); end
    tick();
  endtask

  initial begin
    test_reset();
    test_all_request();
    test_single_requester();
    test_load_stall();
    test_drain_routing();
    test_timeout();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
